vga_draw_arbiter: RTL and testbench

//  Shares the single VGA adapter pixel-write port (plot/x/y/colour) between NUM_REQ drawing engines
//  (home screen, background, tile renderer, game-over screen).

---
 rtl/vga_draw_arbiter_pkg.sv | 10 +
 rtl/vga_draw_arbiter_rr_pick.sv | 26 ++
 rtl/vga_draw_arbiter.sv | 91 +++++++++
 tb/tb_vga_draw_arbiter.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/vga_draw_arbiter_pkg.sv
// vga_draw_arbiter_pkg: shared widths, screen geometry and arbiter state encoding
package vga_draw_arbiter_pkg;
   localparam int COORD_X_W = 8;
   localparam int COORD_Y_W = 7;
   localparam int COLOUR_W  = 3;
   localparam int SCREEN_W  = 160;
   localparam int SCREEN_H  = 120;
   localparam int FRAME_PIX = SCREEN_W * SCREEN_H;
   typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;
endpackage

// File: rtl/vga_draw_arbiter_rr_pick.sv
// vga_draw_arbiter_rr_pick: combinational round-robin picker, first requester after last
module vga_draw_arbiter_rr_pick #(
   parameter int N  = 4,
   parameter int LW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [LW-1:0] last,
   output logic [N-1:0]  next,
   output logic [LW-1:0] idx
);
   // scan from last+1 around the ring, first hit wins
   always_comb begin
      logic found;
      found = 1'b0;
      next  = '0;
      idx   = '0;
      for (int k = 1; k <= N; k++) begin
         automatic int i = (int'(last) + k) % N;
         if (!found && req[i]) begin
            found   = 1'b1;
            next[i] = 1'b1;
            idx     = LW'(i);
         end
      end
   end
endmodule

// File: rtl/vga_draw_arbiter.sv
// vga_draw_arbiter: round-robin owner of the VGA pixel-write port with hold limit and registered output
module vga_draw_arbiter
   import vga_draw_arbiter_pkg::*;
#(
   parameter int NUM_REQ  = 4,
   parameter int X_W      = COORD_X_W,
   parameter int Y_W      = COORD_Y_W,
   parameter int COL_W    = COLOUR_W,
   parameter int MAX_HOLD = FRAME_PIX
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ-1:0]       plot_in,
   input  logic [NUM_REQ*X_W-1:0]   x_in,
   input  logic [NUM_REQ*Y_W-1:0]   y_in,
   input  logic [NUM_REQ*COL_W-1:0] col_in,
   output logic [NUM_REQ-1:0]       grant,
   output logic                     plot_out,
   output logic [X_W-1:0]           x_out,
   output logic [Y_W-1:0]           y_out,
   output logic [COL_W-1:0]         col_out,
   output logic                     busy,
   output logic [7:0]               drop_cnt
);
   localparam int LW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
   localparam int HW = MAX_HOLD > 1 ? $clog2(MAX_HOLD) : 1;

   state_t             state;
   logic [LW-1:0]      owner, last_owner, pick_idx;
   logic [NUM_REQ-1:0] pick;
   logic [HW-1:0]      hold_cnt;
   logic               others, hold_max;

   vga_draw_arbiter_rr_pick #(.N(NUM_REQ), .LW(LW)) u_pick (
      .req  (req),
      .last (last_owner),
      .next (pick),
      .idx  (pick_idx)
   );

   assign others   = |(req & ~grant);
   assign hold_max = hold_cnt == HW'(MAX_HOLD - 1);
   assign busy     = |grant;

   // ownership FSM: every hand-over goes through a zero-grant GAP cycle
   always_ff @(posedge clk)
      if (!resetn) begin
         state      <= IDLE;
         grant      <= '0;
         owner      <= '0;
         last_owner <= LW'(NUM_REQ - 1);
         hold_cnt   <= '0;
      end else
         case (state)
            IDLE:
               if (|req) begin
                  state <= OWN;
                  grant <= pick;
                  owner <= pick_idx;
               end
            OWN: begin
               if (others) hold_cnt <= hold_cnt + 1'b1;
               if (!req[owner] || (hold_max && others)) begin
                  state      <= GAP;
                  grant      <= '0;
                  last_owner <= owner;
                  hold_cnt   <= '0;
               end
            end
            default: state <= IDLE;
         endcase

   // registered pixel stage; coordinates hold while nobody owns the port
   always_ff @(posedge clk)
      if (!resetn) begin
         plot_out <= 1'b0;
         x_out    <= '0;
         y_out    <= '0;
         col_out  <= '0;
         drop_cnt <= '0;
      end else begin
         plot_out <= plot_in[owner] & grant[owner];
         if (busy) begin
            x_out   <= x_in[int'(owner)*X_W +: X_W];
            y_out   <= y_in[int'(owner)*Y_W +: Y_W];
            col_out <= col_in[int'(owner)*COL_W +: COL_W];
         end
         if (|(plot_in & ~grant) && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end
endmodule

// File: tb/tb_vga_draw_arbiter.sv
// tb_vga_draw_arbiter: directed checks of reset, forwarding, rotation, release, drops and mid-job reset
module tb_vga_draw_arbiter;
   logic        clk = 1'b0;
   logic        resetn;
   logic [3:0]  req, plot_in, grant;
   logic [31:0] x_in;
   logic [27:0] y_in;
   logic [11:0] col_in;
   logic        plot_out, busy;
   logic [7:0]  x_out, drop_cnt;
   logic [6:0]  y_out;
   logic [2:0]  col_out;
   int          errors = 0;
   int          checks = 0;
   logic        seen;

   vga_draw_arbiter #(.MAX_HOLD(4)) dut (
      .clk      (clk),
      .resetn   (resetn),
      .req      (req),
      .plot_in  (plot_in),
      .x_in     (x_in),
      .y_in     (y_in),
      .col_in   (col_in),
      .grant    (grant),
      .plot_out (plot_out),
      .x_out    (x_out),
      .y_out    (y_out),
      .col_out  (col_out),
      .busy     (busy),
      .drop_cnt (drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   initial begin
      resetn = 1'b0; req = 4'b1111; plot_in = 4'b1111;
      x_in = '0; y_in = '0; col_in = '0;
      step();
      chk("rst_grant", grant, 0);
      chk("rst_plot", plot_out, 0);
      chk("rst_drop", drop_cnt, 0);
      chk("rst_busy", busy, 0);
      chk("rst_x", x_out, 0);

      resetn = 1'b1; req = 4'b0100; plot_in = 4'b0100;
      x_in[16 +: 8] = 8'd37; y_in[14 +: 7] = 7'd90; col_in[6 +: 3] = 3'b101;
      step();
      chk("single_grant", grant, 4'b0100);
      chk("single_plot0", plot_out, 0);
      chk("single_idle_drop", drop_cnt, 1);
      step();
      chk("single_plot", plot_out, 1);
      chk("single_x", x_out, 37);
      chk("single_y", y_out, 90);
      chk("single_col", col_out, 5);
      chk("single_busy", busy, 1);
      req = 4'b0000; plot_in = 4'b0000;
      step();
      chk("single_gap", grant, 0);
      x_in[16 +: 8] = 8'd99;
      step();
      chk("single_hold_x", x_out, 37);

      resetn = 1'b0;
      step();
      resetn = 1'b1; req = 4'b1111;
      for (int o = 0; o < 4; o++) begin
         for (int c = 0; c < 4; c++) begin
            step();
            chk($sformatf("rot_own%0d_%0d", o, c), grant, 32'(1 << o));
         end
         step();
         chk($sformatf("rot_gap%0d", o), grant, 0);
         step();
         chk($sformatf("rot_idle%0d", o), grant, 0);
      end
      step();
      chk("rot_wrap", grant, 4'b0001);

      resetn = 1'b0;
      step();
      resetn = 1'b1; req = 4'b0010;
      step();
      chk("rel_grant1", grant, 4'b0010);
      req = 4'b1010;
      step();
      chk("rel_keep1", grant, 4'b0010);
      req = 4'b1000;
      step();
      chk("rel_gap", grant, 0);
      step();
      chk("rel_idle", grant, 0);
      step();
      chk("rel_grant3", grant, 4'b1000);

      resetn = 1'b0;
      step();
      resetn = 1'b1; req = 4'b1000;
      step();
      chk("drop_owner", grant, 4'b1000);
      seen = 1'b0;
      for (int p = 0; p < 300; p++) begin
         plot_in = 4'b0001;
         step();
         seen |= plot_out;
         plot_in = 4'b0000;
         step();
         seen |= plot_out;
         if (p == 99) chk("drop_100", drop_cnt, 100);
      end
      chk("drop_sat", drop_cnt, 255);
      chk("drop_noplot", seen, 0);
      chk("drop_keep", grant, 4'b1000);

      req = 4'b0001; plot_in = 4'b0001;
      x_in[0 +: 8] = 8'd200; y_in[0 +: 7] = 7'd3; col_in[0 +: 3] = 3'd6;
      step();
      chk("mid_gap", grant, 0);
      step();
      step();
      chk("mid_grant0", grant, 4'b0001);
      step();
      chk("mid_plot", plot_out, 1);
      chk("mid_x", x_out, 200);
      resetn = 1'b0;
      step();
      chk("mid_rst_grant", grant, 0);
      chk("mid_rst_plot", plot_out, 0);
      chk("mid_rst_x", x_out, 0);
      chk("mid_rst_y", y_out, 0);
      chk("mid_rst_col", col_out, 0);
      chk("mid_rst_drop", drop_cnt, 0);
      resetn = 1'b1; req = 4'b1111; plot_in = 4'b0000;
      step();
      chk("mid_regrant", grant, 4'b0001);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
